// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the flexible synchronous FIFO: occupancy counter width
// and a packed status view used by benches and neighbouring blocks.
package sync_fifo_pkg;

  // The occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, standard or FWFT read mode and sticky errors.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              fifo_data_in,
  input  logic                          fifo_write,
  input  logic                          fifo_read,
  input  logic                          fifo_err_clr,
  output logic [WIDTH-1:0]              fifo_data_out,
  output logic                          fifo_data_valid,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   fifo_count,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DEPTH < 2) || (AF_LEVEL < 1) || (AF_LEVEL > DEPTH) ||
      (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : gParamCheck
    $error("sync_fifo_flex: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_almostFull;
  logic             r_almostEmpty;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wrAcc;
  logic             w_rdAcc;
  logic [CW-1:0]    w_cntNext;
  logic [AW-1:0]    w_wrPtrNext;
  logic [AW-1:0]    w_rdPtrNext;
  logic [WIDTH-1:0] w_rdata;

  // Acceptance uses the registered pre-edge flags, so a full FIFO rejects a
  // write even when a read is popping in the same cycle (and vice versa).
  assign w_wrAcc = fifo_write & ~r_full;
  assign w_rdAcc = fifo_read  & ~r_empty;

  // Explicit wrap keeps non-power-of-2 depths correct.
  assign w_wrPtrNext = (r_wrPtr == AW'(DEPTH - 1)) ? '0 : r_wrPtr + AW'(1);
  assign w_rdPtrNext = (r_rdPtr == AW'(DEPTH - 1)) ? '0 : r_rdPtr + AW'(1);

  always_comb begin
    w_cntNext = r_count;
    if (w_wrAcc && !w_rdAcc) begin
      w_cntNext = r_count + CW'(1);
    end else if (!w_wrAcc && w_rdAcc) begin
      w_cntNext = r_count - CW'(1);
    end
  end

  // Flags derive from the next count so they settle with the count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wrAcc) r_wrPtr <= w_wrPtrNext;
      if (w_rdAcc) r_rdPtr <= w_rdPtrNext;
      r_count       <= w_cntNext;
      r_full        <= (w_cntNext == CW'(DEPTH));
      r_empty       <= (w_cntNext == '0);
      r_almostFull  <= (w_cntNext >= CW'(AF_LEVEL));
      r_almostEmpty <= (w_cntNext <= CW'(AE_LEVEL));
      if (fifo_write && r_full)  r_overflow  <= 1'b1;
      else if (fifo_err_clr)     r_overflow  <= 1'b0;
      if (fifo_read && r_empty)  r_underflow <= 1'b1;
      else if (fifo_err_clr)     r_underflow <= 1'b0;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uRam (
    .clk   (clk),
    .we    (w_wrAcc),
    .waddr (r_wrPtr),
    .wdata (fifo_data_in),
    .raddr (r_rdPtr),
    .rdata (w_rdata)
  );

  if (FWFT == 0) begin : gStdRead
    logic [WIDTH-1:0] r_dataOut;
    logic             r_dataValid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dataOut   <= '0;
        r_dataValid <= 1'b0;
      end else begin
        r_dataValid <= w_rdAcc;
        if (w_rdAcc) r_dataOut <= w_rdata;
      end
    end

    assign fifo_data_out   = r_dataOut;
    assign fifo_data_valid = r_dataValid;
  end else begin : gFwftRead
    // Head word is shown directly; an empty FIFO presents zero.
    assign fifo_data_out   = r_empty ? '0 : w_rdata;
    assign fifo_data_valid = ~r_empty;
  end

  assign fifo_full         = r_full;
  assign fifo_empty        = r_empty;
  assign fifo_almost_full  = r_almostFull;
  assign fifo_almost_empty = r_almostEmpty;
  assign fifo_count        = r_count;
  assign fifo_overflow     = r_overflow;
  assign fifo_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench: three FIFOs (std/16, FWFT/16, std/5) share one directed
// stimulus stream; a queue model predicts status and popped words.
module tb_sync_fifo_flex;
  import sync_fifo_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] fifoDataIn;
  logic        fifoWrite;
  logic        fifoRead;
  logic        fifoErrClr;

  logic [15:0] aDataOut, bDataOut, cDataOut;
  logic        aValid, bValid, cValid;
  logic        aFull, bFull, cFull;
  logic        aEmpty, bEmpty, cEmpty;
  logic        aAf, bAf, cAf;
  logic        aAe, bAe, cAe;
  logic [4:0]  aCount, bCount;
  logic [2:0]  cCount;
  logic        aOvf, bOvf, cOvf;
  logic        aUnf, bUnf, cUnf;

  int checks = 0;
  int passes = 0;

  logic [15:0] modA[$];
  logic [15:0] modC[$];
  logic [15:0] expA[$];
  logic [15:0] expB[$];
  logic [15:0] expC[$];
  logic [15:0] lastA, lastC;
  logic        ovfA, unfA, ovfC, unfC;
  logic        vldA, vldC;

  sync_fifo_flex #(.WIDTH(16), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dutA (
    .clk(clk), .rst(rst), .fifo_data_in(fifoDataIn), .fifo_write(fifoWrite),
    .fifo_read(fifoRead), .fifo_err_clr(fifoErrClr), .fifo_data_out(aDataOut),
    .fifo_data_valid(aValid), .fifo_full(aFull), .fifo_empty(aEmpty),
    .fifo_almost_full(aAf), .fifo_almost_empty(aAe), .fifo_count(aCount),
    .fifo_overflow(aOvf), .fifo_underflow(aUnf));

  sync_fifo_flex #(.WIDTH(16), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dutB (
    .clk(clk), .rst(rst), .fifo_data_in(fifoDataIn), .fifo_write(fifoWrite),
    .fifo_read(fifoRead), .fifo_err_clr(fifoErrClr), .fifo_data_out(bDataOut),
    .fifo_data_valid(bValid), .fifo_full(bFull), .fifo_empty(bEmpty),
    .fifo_almost_full(bAf), .fifo_almost_empty(bAe), .fifo_count(bCount),
    .fifo_overflow(bOvf), .fifo_underflow(bUnf));

  sync_fifo_flex #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) dutC (
    .clk(clk), .rst(rst), .fifo_data_in(fifoDataIn), .fifo_write(fifoWrite),
    .fifo_read(fifoRead), .fifo_err_clr(fifoErrClr), .fifo_data_out(cDataOut),
    .fifo_data_valid(cValid), .fifo_full(cFull), .fifo_empty(cEmpty),
    .fifo_almost_full(cAf), .fifo_almost_empty(cAe), .fifo_count(cCount),
    .fifo_overflow(cOvf), .fifo_underflow(cUnf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s: got unexpected output word, required none (t=%0t)", name, $time);
  endtask

  function automatic fifo_status_t expStatus(input int n, input int depth, input int afl,
                                             input int ael, input logic o, input logic u);
    fifo_status_t s;
    s.full         = (n == depth);
    s.empty        = (n == 0);
    s.almost_full  = (n >= afl);
    s.almost_empty = (n <= ael);
    s.overflow     = o;
    s.underflow    = u;
    return s;
  endfunction

  function automatic fifo_status_t actStatus(input logic f, input logic e, input logic af,
                                             input logic ae, input logic o, input logic u);
    fifo_status_t s;
    s.full = f; s.empty = e; s.almost_full = af; s.almost_empty = ae;
    s.overflow = o; s.underflow = u;
    return s;
  endfunction

  task automatic checkOutput();
    chk("A.status", 32'(actStatus(aFull, aEmpty, aAf, aAe, aOvf, aUnf)),
        32'(expStatus(modA.size(), 16, 12, 4, ovfA, unfA)));
    chk("A.count", 32'(aCount), 32'(modA.size()));
    chk("A.valid", 32'(aValid), 32'(vldA));
    chk("A.dataOut", 32'(aDataOut), 32'(lastA));
    chk("B.status", 32'(actStatus(bFull, bEmpty, bAf, bAe, bOvf, bUnf)),
        32'(expStatus(modA.size(), 16, 12, 4, ovfA, unfA)));
    chk("B.count", 32'(bCount), 32'(modA.size()));
    chk("B.valid", 32'(bValid), 32'(modA.size() != 0));
    if (modA.size() != 0) chk("B.headWord", 32'(bDataOut), 32'(modA[0]));
    chk("C.status", 32'(actStatus(cFull, cEmpty, cAf, cAe, cOvf, cUnf)),
        32'(expStatus(modC.size(), 5, 4, 1, ovfC, unfC)));
    chk("C.count", 32'(cCount), 32'(modC.size()));
    chk("C.valid", 32'(cValid), 32'(vldC));
    chk("C.dataOut", 32'(cDataOut), 32'(lastC));
  endtask

  // Drive one cycle of requests, advance the queue models, check after the edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic clr,
                               input logic [15:0] d);
    logic [15:0] w;
    logic fullA, emptyA, fullC, emptyC;
    @(negedge clk);
    fifoWrite = wr; fifoRead = rd; fifoErrClr = clr; fifoDataIn = d;
    fullA  = (modA.size() == 16);
    emptyA = (modA.size() == 0);
    fullC  = (modC.size() == 5);
    emptyC = (modC.size() == 0);
    vldA = rd && !emptyA;
    if (vldA) begin
      w = modA.pop_front();
      lastA = w;
      expA.push_back(w);
      expB.push_back(w);
    end
    if (wr && !fullA) modA.push_back(d);
    if (wr && fullA) ovfA = 1'b1; else if (clr) ovfA = 1'b0;
    if (rd && emptyA) unfA = 1'b1; else if (clr) unfA = 1'b0;
    vldC = rd && !emptyC;
    if (vldC) begin
      w = modC.pop_front();
      lastC = w;
      expC.push_back(w);
    end
    if (wr && !fullC) modC.push_back(d);
    if (wr && fullC) ovfC = 1'b1; else if (clr) ovfC = 1'b0;
    if (rd && emptyC) unfC = 1'b1; else if (clr) unfC = 1'b0;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Reset with live requests that must be ignored.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; fifoWrite = 1'b1; fifoRead = 1'b1; fifoErrClr = 1'b0; fifoDataIn = 16'hdead;
    @(posedge clk);
    #1;
    modA.delete(); modC.delete();
    lastA = '0; lastC = '0;
    ovfA = 1'b0; unfA = 1'b0; ovfC = 1'b0; unfC = 1'b0;
    vldA = 1'b0; vldC = 1'b0;
    checkOutput();
    @(negedge clk);
    rst = 1'b0; fifoWrite = 1'b0; fifoRead = 1'b0;
  endtask

  // Monitor: std outputs pop on data_valid, FWFT pops on an accepted read.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (aValid) begin
        if (expA.size() == 0) failNow("A.popData");
        else chk("A.popData", 32'(aDataOut), 32'(expA.pop_front()));
      end
      if (cValid) begin
        if (expC.size() == 0) failNow("C.popData");
        else chk("C.popData", 32'(cDataOut), 32'(expC.pop_front()));
      end
      if (!rst && fifoRead && bValid) begin
        if (expB.size() == 0) failNow("B.popData");
        else chk("B.popData", 32'(bDataOut), 32'(expB.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; fifoWrite = 1'b0; fifoRead = 1'b0; fifoErrClr = 1'b0; fifoDataIn = '0;
    lastA = '0; lastC = '0; ovfA = 1'b0; unfA = 1'b0; ovfC = 1'b0; unfC = 1'b0;
    vldA = 1'b0; vldC = 1'b0;
    doReset();

    // Fill past full: 17th write overflows depth 16, 6th overflows depth 5.
    for (int i = 1; i <= 17; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(i));
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h00f0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h00f1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);

    // Drain plus one underflowing read, then write+read while empty.
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0100);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);

    // Steady state at occupancy 8 with pointer wrap.
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i));
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0200 + 16'(i));
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

    // Mid-stream reset at count 7, then single write into empty.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'habcd);
    for (int i = 1; i <= 15; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0300 + 16'(i));
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h03ff);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

    chk("A.queueDrained", 32'(expA.size()), 32'd0);
    chk("B.queueDrained", 32'(expB.size()), 32'd0);
    chk("C.queueDrained", 32'(expC.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
